ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter, the other direction of the keyboard receive path.
- Sends one command byte to the keyboard, e.g. ED (set LEDs) or FF (reset).
- Drives the open-drain PS/2 clock/data lines through pad output-enables and reports device ACK, NACK or timeout.
- Sits beside the keyboard receiver on the same two PS/2 lines; receive logic ignores the lines while tx_ready=0.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles the host holds PS/2 clock low before the request-to-send (100 us at 50 MHz); minimum 2.
- TIMEOUT_CYCLES, 750000: maximum clk cycles allowed waiting for any device clock falling edge (15 ms at 50 MHz).
- CNT_W, 20: width of the shared inhibit/timeout counter; must hold max(INHIBIT_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk, input, 1: system clock.
- res, input, 1: asynchronous, active-high reset.
- tx_data, input, 8: command byte; sampled on the accept cycle.
- tx_valid, input, 1: request to send.
- tx_ready, output, 1: high only in IDLE; accept = tx_valid & tx_ready.
- ps2_clk_in, input, 1: raw PS/2 clock pad level (asynchronous).
- ps2_data_in, input, 1: raw PS/2 data pad level (asynchronous).
- ps2_clk_oe, output, 1: 1 = pull PS/2 clock low; 0 = release.
- ps2_data_oe, output, 1: 1 = pull PS/2 data low; 0 = release.
- done, output, 1: one-cycle pulse when a transfer ends.
- ack_ok, output, 1: valid with done; 1 = device ACK received.
- err, output, 1: valid with done; 1 = timeout, NACK, or bus not idle at end.

Behaviour:
- Reset values: ps2_clk_oe=0, ps2_data_oe=0, tx_ready=0 while res is asserted (1 on the first cycle after release), done=0, ack_ok=0, err=0, state=IDLE, counters 0.
- Reset mid-transfer releases both lines immediately and asynchronously; no done pulse is generated.
- Inputs pass through a 2-FF synchronizer. fall = synced clock was 1 last cycle and is 0 now.
- A fall is seen about 3 clk cycles after the pad edge.
- State machine:
  - IDLE: on accept, latch tx_data into shift[7:0], compute parity = ~^tx_data (odd parity), and go to INHIBIT.
  - INHIBIT: clk_oe=1. Count INHIBIT_CYCLES. On the last cycle assert data_oe=1 (start bit), then go to REQ.
  - REQ: clk_oe=0, data_oe=1. Wait for a fall; the timeout counter runs.
  - SEND: bit index n runs 0..9.
    - Each fall drives the next bit: data_oe = ~bit.
    - n=0..7 are shift[0..7] (LSB first), n=8 is parity, n=9 is release (data_oe=0, stop bit).
    - After the 10th fall in SEND go to ACK. That is the 11th device fall overall, counting the fall seen in REQ.
  - ACK: on the next fall, sample synced data. 0 = ACK, 1 = NACK. Go to WAIT_IDLE.
  - WAIT_IDLE: wait until synced clock and data are both 1, then go to FINISH. The timeout counter runs.
  - FINISH: pulse done for one cycle with ack_ok/err, then return to IDLE.
- Bits change only on a fall, so the device samples a stable level on its rising edge.
- Timeout: in REQ, SEND, ACK and WAIT_IDLE the counter clears on every fall. If it reaches TIMEOUT_CYCLES: release both lines, go to FINISH, err=1, ack_ok=0.
- NACK: err=1, ack_ok=0. ACK: ack_ok=1, err=0.
- tx_valid while busy is ignored (tx_ready=0). A back-to-back request is accepted in the IDLE cycle after FINISH.
- The module never drives the pads high. Outputs are registered.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined: on NACK or timeout, automatically re-run from INHIBIT with the latched byte, up to 2 retries. done pulses only after success or after the final failure; err reflects the final attempt.
- Undefined: no retry; the first failure is reported.

Decomposition:
- ps2_pkg holds:
  - state enum ps2_tx_state_t: IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE, FINISH.
  - constants PS2_CMD_SET_LEDS=8'hED, PS2_CMD_RESET=8'hFF, PS2_CMD_ECHO=8'hEE.
  - function ps2_odd_parity.
- Sub-module ps2_line_sync: 2-FF synchronizer for clock and data plus the fall output. It is reused by the receiver.

Test Plan (bench: INHIBIT_CYCLES=8, TIMEOUT_CYCLES=64; device model clocks at a 20-cycle half period):
- Send 0xED → clk_oe high for 8 cycles, start bit 0, then data line 1,0,1,1,0,1,1,1, parity 1, stop 1. Model ACKs → done with ack_ok=1, err=0.
- Send 0x01 → parity bit 0. Send 0xFF → parity 1. The model checks all 11 bits and the received byte.
- Device never clocks after the request → after 64 cycles in REQ both oe=0, done with err=1, ack_ok=0.
- Device holds data high in the ACK slot → done with err=1. With PS2_TX_RETRY_EN: 3 INHIBIT phases observed, then one done.
- Assert res during bit 4 → ps2_clk_oe=ps2_data_oe=0 in the same cycle, no done; tx_ready=1 after release.
- tx_valid held high through a transfer of 0xEE → exactly one frame sent; second request accepted right after FINISH.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 types, command codes and parity helper.
// Used by the host transmitter and the keyboard receive path.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE,
        FINISH
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;

    function automatic logic ps2_odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake, result flags and PS/2 pad signals.
// master = command source / pad side, slave = transmitter.
interface ps2_host_tx_if;
    import ps2_pkg::*;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       done;
    logic       ack_ok;
    logic       err;

    modport master (
        output tx_data, tx_valid, ps2_clk_in, ps2_data_in,
        input  tx_ready, ps2_clk_oe, ps2_data_oe, done, ack_ok, err
    );

    modport slave (
        input  tx_data, tx_valid, ps2_clk_in, ps2_data_in,
        output tx_ready, ps2_clk_oe, ps2_data_oe, done, ack_ok, err
    );

endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronizer for PS/2 clock/data plus clock fall.
// Resets to the idle (high) bus level so no false fall follows reset.
module ps2_line_sync (
    input  logic clk,
    input  logic res,
    input  logic clk_pad,
    input  logic data_pad,
    output logic clk_s,
    output logic data_s,
    output logic fall
);
    logic [1:0] c_ff;
    logic [1:0] d_ff;
    logic       c_prev;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            c_ff   <= 2'b11;
            d_ff   <= 2'b11;
            c_prev <= 1'b1;
        end else begin
            c_ff   <= {c_ff[0], clk_pad};
            d_ff   <= {d_ff[0], data_pad};
            c_prev <= c_ff[1];
        end
    end

    assign clk_s  = c_ff[1];
    assign data_s = d_ff[1];
    assign fall   = c_prev & ~c_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with ACK check.
// Define PS2_TX_RETRY_EN to retry NACK/timeout up to two times.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int CNT_W          = 20
) (
    input logic          clk,
    input logic          res,
    ps2_host_tx_if.slave bus
);
    localparam logic [CNT_W-1:0] INH_PRE  = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       shift_q, shift_d;
    logic [3:0]       n_q, n_d;
    logic             fail_q, fail_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             ready_q, done_q, ack_q, err_q;
    logic             clk_s, data_s, fall;
    logic             timed, timeout, accept;
`ifdef PS2_TX_RETRY_EN
    logic [1:0]       retry_q, retry_d;
`endif

    ps2_line_sync u_sync (
        .clk     (clk),
        .res     (res),
        .clk_pad (bus.ps2_clk_in),
        .data_pad(bus.ps2_data_in),
        .clk_s   (clk_s),
        .data_s  (data_s),
        .fall    (fall)
    );

    assign accept  = bus.tx_valid & ready_q;
    assign timed   = state_q inside {REQ, SEND, ACK, WAIT_IDLE};
    assign timeout = timed & ~fall & (cnt_q == TO_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        n_d       = n_q;
        fail_d    = fail_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
`ifdef PS2_TX_RETRY_EN
        retry_d   = retry_q;
`endif
        if (timed) cnt_d = fall ? '0 : cnt_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    // bit 9 is the stop slot: ~1 releases data
                    shift_d = {1'b1, ps2_odd_parity(bus.tx_data), bus.tx_data};
                    cnt_d     = '0;
                    fail_d    = 1'b0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
                    retry_d   = '0;
`endif
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                cnt_d    = cnt_q + 1'b1;
                clk_oe_d = 1'b1;
                if (cnt_q == INH_PRE) data_oe_d = 1'b1;
                if (cnt_q == INH_LAST) begin
                    clk_oe_d = 1'b0;
                    cnt_d    = '0;
                    n_d      = '0;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (fall) state_d = SEND;
            end
            SEND: begin
                if (fall) begin
                    data_oe_d = ~shift_q[n_q];
                    n_d       = n_q + 4'd1;
                    if (n_q == 4'd9) state_d = ACK;
                end
            end
            ACK: begin
                if (fall) begin
                    fail_d  = data_s;
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_s && data_s) state_d = FINISH;
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (timeout) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            fail_d    = 1'b1;
            state_d   = FINISH;
        end
`ifdef PS2_TX_RETRY_EN
        if (state_d == FINISH && fail_d && retry_q != 2'd2) begin
            retry_d   = retry_q + 2'd1;
            fail_d    = 1'b0;
            cnt_d     = '0;
            clk_oe_d  = 1'b1;
            data_oe_d = 1'b0;
            state_d   = INHIBIT;
        end
`endif
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            n_q       <= '0;
            fail_q    <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            n_q       <= n_d;
            fail_q    <= fail_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            ready_q   <= (state_d == IDLE);
            done_q    <= (state_d == FINISH);
            ack_q     <= (state_d == FINISH) & ~fail_d;
            err_q     <= (state_d == FINISH) & fail_d;
        end
    end

`ifdef PS2_TX_RETRY_EN
    always_ff @(posedge clk or posedge res) begin
        if (res) retry_q <= '0;
        else     retry_q <= retry_d;
    end
`endif

    assign bus.tx_ready    = ready_q;
    assign bus.ps2_clk_oe  = clk_oe_q;
    assign bus.ps2_data_oe = data_oe_q;
    assign bus.done        = done_q;
    assign bus.ack_ok      = ack_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a PS/2 device model and scoreboard.
// Honours PS2_TX_RETRY_EN for the NACK/timeout attempt counts.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 8;
    localparam int TMO = 64;
    localparam int HP  = 20;
`ifdef PS2_TX_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic clk = 1'b0;
    logic res = 1'b1;
    logic dev_clk = 1'b1;
    logic dev_low = 1'b0;

    always #5 clk = ~clk;

    ps2_host_tx_if bus();

    // open-drain wired-AND of host and device drivers
    assign bus.ps2_clk_in  = dev_clk & ~bus.ps2_clk_oe;
    assign bus.ps2_data_in = ~dev_low & ~bus.ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (20)
    ) dut (
        .clk(clk),
        .res(res),
        .bus(bus)
    );

    int nchk = 0;
    int npass = 0;
    int nfail = 0;

    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   accepts = 0;
    int   accept_cyc = 0;
    int   inh_phases = 0;
    int   inh_run = 0;
    int   inh_len = 0;
    int   req_run = 0;
    logic inh_last = 1'b0;
    logic prev_clk_oe = 1'b0;
    logic last_ack = 1'b0;
    logic last_err = 1'b0;

    logic [10:0] exp_frames[$];
    logic [1:0]  exp_res[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            last_ack <= bus.ack_ok;
            last_err <= bus.err;
        end
        if (bus.ps2_clk_oe) begin
            if (!prev_clk_oe) begin
                inh_phases <= inh_phases + 1;
                inh_run    <= 1;
                req_run    <= 0;
            end else begin
                inh_run <= inh_run + 1;
            end
            inh_last <= bus.ps2_data_oe;
        end else if (prev_clk_oe) begin
            inh_len <= inh_run;
        end
        if (!bus.ps2_clk_oe && bus.ps2_data_oe) req_run <= req_run + 1;
        if (bus.tx_valid && bus.tx_ready) begin
            accepts    <= accepts + 1;
            accept_cyc <= cyc;
        end
        prev_clk_oe <= bus.ps2_clk_oe;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        nchk++;
        assert (got === want) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic send(input logic [7:0] d);
        int t;
        t = 0;
        while (!bus.tx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("ready_before_send", bus.tx_ready, 1);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic dev(input logic give_ack, input int nbits,
                       output logic [10:0] bits);
        int t;
        bits = '0;
        t = 0;
        while (!(bus.ps2_data_oe && !bus.ps2_clk_oe) && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("req_seen", t < 400, 1);
        repeat (10) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            dev_clk = 1'b0;
            repeat (HP) @(negedge clk);
            dev_clk = 1'b1;
            bits[i] = bus.ps2_data_in;
            if (i == 10) dev_low = give_ack;
            repeat (HP) @(negedge clk);
        end
        if (nbits == 11) begin
            dev_clk = 1'b0;
            repeat (HP) @(negedge clk);
            dev_clk = 1'b1;
            repeat (HP) @(negedge clk);
            dev_low = 1'b0;
        end
    endtask

    task automatic wait_done(input int d0, input int budget);
        int t;
        t = 0;
        while (done_cnt == d0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("done_once", done_cnt - d0, 1);
    endtask

    task automatic chk_result();
        logic [1:0] e;
        e = exp_res.pop_front();
        chk("ack_ok", last_ack, e[1]);
        chk("err", last_err, e[0]);
    endtask

    task automatic xfer(input logic [7:0] d, input logic [10:0] frame,
                        input logic give_ack);
        int d0, p0, n;
        logic [10:0] bits, e;
        n  = give_ack ? 1 : ATTEMPTS;
        d0 = done_cnt;
        p0 = inh_phases;
        exp_res.push_back(give_ack ? 2'b10 : 2'b01);
        send(d);
        for (int a = 0; a < n; a++) begin
            exp_frames.push_back(frame);
            dev(give_ack, 11, bits);
            e = exp_frames.pop_front();
            chk("frame", bits, e);
        end
        wait_done(d0, 400);
        chk("inh_phases", inh_phases - p0, n);
        chk("inh_len", inh_len, INH);
        chk("start_in_inhibit", inh_last, 1);
        chk_result();
    endtask

    initial begin
        int d0, p0, a0;
        logic [10:0] bits, e;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_clk_oe", bus.ps2_clk_oe, 0);
        chk("rst_data_oe", bus.ps2_data_oe, 0);
        chk("rst_ready", bus.tx_ready, 0);
        chk("rst_done", bus.done, 0);
        res = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", bus.tx_ready, 1);

        xfer(PS2_CMD_SET_LEDS, {1'b1, 1'b1, 8'hED, 1'b0}, 1'b1);
        xfer(8'h01, {1'b1, 1'b0, 8'h01, 1'b0}, 1'b1);
        xfer(PS2_CMD_RESET, {1'b1, 1'b1, 8'hFF, 1'b0}, 1'b1);

        // NACK: device leaves data high in the ACK slot
        xfer(8'hF3, {1'b1, 1'b1, 8'hF3, 1'b0}, 1'b0);

        // timeout: device never clocks
        d0 = done_cnt;
        p0 = inh_phases;
        exp_res.push_back(2'b01);
        send(8'h55);
        wait_done(d0, 1200);
        chk("to_req_cycles", req_run, TMO);
        chk("to_inh_phases", inh_phases - p0, ATTEMPTS);
        chk("to_clk_oe", bus.ps2_clk_oe, 0);
        chk("to_data_oe", bus.ps2_data_oe, 0);
        chk_result();

        // reset while bit 4 (a zero) is on the line
        d0 = done_cnt;
        send(8'hA5);
        dev(1'b1, 6, bits);
        chk("part_frame", bits[5:0], 6'b001010);
        chk("pre_rst_data_oe", bus.ps2_data_oe, 1);
        @(negedge clk);
        #2 res = 1'b1;
        #1;
        chk("mid_rst_clk_oe", bus.ps2_clk_oe, 0);
        chk("mid_rst_data_oe", bus.ps2_data_oe, 0);
        repeat (3) @(negedge clk);
        chk("mid_rst_ready", bus.tx_ready, 0);
        res = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_ready", bus.tx_ready, 1);
        chk("post_rst_no_done", done_cnt - d0, 0);

        // tx_valid held high: one frame, re-accept right after FINISH
        d0 = done_cnt;
        a0 = accepts;
        exp_res.push_back(2'b10);
        exp_res.push_back(2'b10);
        bus.tx_data  = PS2_CMD_ECHO;
        bus.tx_valid = 1'b1;
        exp_frames.push_back({1'b1, 1'b1, 8'hEE, 1'b0});
        dev(1'b1, 11, bits);
        e = exp_frames.pop_front();
        chk("b2b_frame1", bits, e);
        chk("b2b_one_accept", accepts - a0, 1);
        wait_done(d0, 400);
        chk_result();
        bus.tx_valid = 1'b0;
        chk("b2b_two_accepts", accepts - a0, 2);
        chk("b2b_accept_gap", accept_cyc - done_cyc, 1);
        exp_frames.push_back({1'b1, 1'b1, 8'hEE, 1'b0});
        dev(1'b1, 11, bits);
        e = exp_frames.pop_front();
        chk("b2b_frame2", bits, e);
        wait_done(d0 + 1, 400);
        chk_result();
        chk("b2b_no_third", accepts - a0, 2);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
